// File: rtl/pulse_scheduler.sv
// Frame scheduler: runs a period counter for a programmed number of frames and
// fires one-cycle pulses on each enabled channel at its configured match count.
module pulse_scheduler #(
  parameter int CNT_W = 5,
  parameter int NCH   = 3,
  parameter int FRM_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [FRM_W-1:0] frames,
  input  logic [CNT_W-1:0] period,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_match,
  input  logic             cfg_en,
  output logic             busy,
  output logic [CNT_W-1:0] cnt,
  output logic [NCH-1:0]   pulse,
  output logic             control,
  output logic             frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOPPING} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [FRM_W-1:0] frm_q, frm_d;
  logic [CNT_W-1:0] match_q [NCH];
  logic [CNT_W-1:0] match_d [NCH];
  logic [NCH-1:0]   en_q, en_d;
  logic [NCH-1:0]   pulse_q, pulse_d;
  logic             control_q, control_d;
  logic             frame_done_q, frame_done_d;

  function automatic logic [CNT_W-1:0] match_rst(input int ch);
    case (ch)
      0:       match_rst = CNT_W'(4);
      1:       match_rst = CNT_W'(20);
      2:       match_rst = CNT_W'(24);
      default: match_rst = '0;
    endcase
  endfunction

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_d     = period_q;
    frm_d        = frm_q;
    match_d      = match_q;
    en_d         = en_q;
    pulse_d      = '0;
    control_d    = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (cfg_we && (int'(cfg_sel) < NCH)) begin
          match_d[cfg_sel] = cfg_match;
          en_d[cfg_sel]    = cfg_en;
        end
        if (start) begin
          state_d  = S_RUN;
          period_d = period;
          frm_d    = frames;
        end
      end
      S_RUN, S_STOPPING: begin
        if (cnt_q == period_q) begin
          cnt_d = '0;
          // A frame count of 0 means continuous; only a finite count reaching 1 ends the run.
          if ((state_q == S_STOPPING) || stop || (frm_q == FRM_W'(1))) state_d = S_IDLE;
          if (frm_q != '0) frm_d = frm_q - 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (stop && (state_q == S_RUN)) state_d = S_STOPPING;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are computed from next-cycle values so the registered pulses line up with cnt.
    if (state_d != S_IDLE) begin
      for (int i = 0; i < NCH; i++) pulse_d[i] = en_d[i] && (cnt_d == match_d[i]);
      frame_done_d = (cnt_d == period_d);
    end
    control_d = |pulse_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      period_q     <= CNT_W'(31);
      frm_q        <= '0;
      en_q         <= '1;
      pulse_q      <= '0;
      control_q    <= 1'b0;
      frame_done_q <= 1'b0;
      // NOTE: the match array holds architectural reset values, so it is reset like any flop.
      for (int i = 0; i < NCH; i++) match_q[i] <= match_rst(i);
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      period_q     <= period_d;
      frm_q        <= frm_d;
      en_q         <= en_d;
      pulse_q      <= pulse_d;
      control_q    <= control_d;
      frame_done_q <= frame_done_d;
      match_q      <= match_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign cnt        = cnt_q;
  assign pulse      = pulse_q;
  assign control    = control_q;
  assign frame_done = frame_done_q;

endmodule
